// File: rtl/ladder_trace_if.sv
// rtl/ladder_trace_if.sv - button and display bundle for the ladder-lottery engine
interface ladder_trace_if #(
    parameter int LANES = 6,
    parameter int ROWS  = 8
);
    localparam int LW = ($clog2(LANES) > 1) ? $clog2(LANES) : 1;
    localparam int RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;

    logic                        up;
    logic                        down;
    logic                        left;
    logic                        right;
    logic                        enter;
    logic                        esc;
    logic                        mode;
    logic [ROWS*(LANES-1)-1:0]   rung_map;
    logic [RW-1:0]               cursor_row;
    logic [LW-1:0]               cursor_col;
    logic [LW-1:0]               start_lane;
    logic [LW-1:0]               trace_lane;
    logic [RW-1:0]               trace_row;
    logic [LW-1:0]               result;
    logic                        result_valid;
    logic                        alarm;
    logic                        norm;

    // Button front end side
    modport master (
        output up, down, left, right, enter, esc, mode,
        input  rung_map, cursor_row, cursor_col, start_lane, trace_lane,
               trace_row, result, result_valid, alarm, norm
    );

    // Ladder engine side
    modport slave (
        input  up, down, left, right, enter, esc, mode,
        output rung_map, cursor_row, cursor_col, start_lane, trace_lane,
               trace_row, result, result_valid, alarm, norm
    );
endinterface

// File: rtl/ladder_trace.sv
// rtl/ladder_trace.sv - amidakuji rung editor and timed trace engine
module ladder_trace #(
    parameter int LANES    = 6,
    parameter int ROWS     = 8,
    parameter int TICK_DIV = 25_000_000
) (
    input logic           clk,
    input logic           rst,
    ladder_trace_if.slave bus
);
    localparam int LW = ($clog2(LANES) > 1) ? $clog2(LANES) : 1;
    localparam int RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;
    localparam int NC = LANES - 1;
    localparam int NB = ROWS * NC;
    localparam int CW = ($clog2(TICK_DIV + 1) > 1) ? $clog2(TICK_DIV + 1) : 1;

    typedef enum logic [1:0] {EDIT, SELECT, TRACE, DONE} state_t;

    state_t        state;
    logic [NB-1:0] rungs;
    logic [RW-1:0] cursor_row;
    logic [LW-1:0] cursor_col;
    logic [LW-1:0] start_lane;
    logic [LW-1:0] trace_lane;
    logic [RW-1:0] trace_row;
    logic [LW-1:0] result;
    logic          result_valid;
    logic          alarm;
    logic          norm;
    logic [CW-1:0] tick;

    logic          cur_rung;
    logic          nbr_set;
    logic [NB-1:0] cur_mask;
    logic [LW-1:0] step_lane;

    // Out-of-range columns read as empty, so edge lanes need no special casing
    function automatic logic rung_at(input logic [NB-1:0] map, input int row, input int col);
        logic [NB-1:0] sh;
        if (col < 0 || col >= NC || row < 0 || row >= ROWS) begin
            return 1'b0;
        end
        sh = map >> (row * NC + col);
        return sh[0];
    endfunction

    // Cursor rung state, neighbour legality and the lane after the current trace row
    always_comb begin
        cur_rung  = rung_at(rungs, int'(cursor_row), int'(cursor_col));
        nbr_set   = rung_at(rungs, int'(cursor_row), int'(cursor_col) - 1)
                  | rung_at(rungs, int'(cursor_row), int'(cursor_col) + 1);
        cur_mask  = NB'(1) << (int'(cursor_row) * NC + int'(cursor_col));
        step_lane = trace_lane;
        if (rung_at(rungs, int'(trace_row), int'(trace_lane))) begin
            step_lane = trace_lane + LW'(1);
        end else if (rung_at(rungs, int'(trace_row), int'(trace_lane) - 1)) begin
            step_lane = trace_lane - LW'(1);
        end
    end

    // Main state machine; norm and alarm are updated together with every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EDIT;
            rungs        <= '0;
            cursor_row   <= '0;
            cursor_col   <= '0;
            start_lane   <= '0;
            trace_lane   <= '0;
            trace_row    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            alarm        <= 1'b0;
            norm         <= 1'b1;
            tick         <= '0;
        end else if (!bus.mode && state != EDIT) begin
            state <= EDIT;
            norm  <= 1'b1;
            alarm <= 1'b0;
        end else begin
            case (state)
                EDIT: begin
                    if (bus.mode) begin
                        state <= SELECT;
                        norm  <= 1'b0;
                    end else if (bus.esc) begin
                        rungs        <= '0;
                        result_valid <= 1'b0;
                    end else if (bus.enter) begin
                        if (cur_rung || !nbr_set) begin
                            rungs        <= rungs ^ cur_mask;
                            result_valid <= 1'b0;
                        end
                    end else if (bus.up) begin
                        cursor_row <= (cursor_row == '0) ? RW'(ROWS - 1) : cursor_row - RW'(1);
                    end else if (bus.down) begin
                        cursor_row <= (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + RW'(1);
                    end else if (bus.left) begin
                        cursor_col <= (cursor_col == '0) ? LW'(LANES - 2) : cursor_col - LW'(1);
                    end else if (bus.right) begin
                        cursor_col <= (cursor_col == LW'(LANES - 2)) ? '0 : cursor_col + LW'(1);
                    end
                end
                SELECT: begin
                    if (bus.esc) begin
                        state <= EDIT;
                        norm  <= 1'b1;
                    end else if (bus.enter) begin
                        state      <= TRACE;
                        trace_lane <= start_lane;
                        trace_row  <= '0;
                        tick       <= '0;
                    end else if (bus.up || bus.down) begin
                        // higher-priority pulse with no meaning here masks left/right
                        start_lane <= start_lane;
                    end else if (bus.left) begin
                        start_lane <= (start_lane == '0) ? LW'(LANES - 1) : start_lane - LW'(1);
                    end else if (bus.right) begin
                        start_lane <= (start_lane == LW'(LANES - 1)) ? '0 : start_lane + LW'(1);
                    end
                end
                TRACE: begin
                    if (bus.esc) begin
                        state <= SELECT;
                        alarm <= 1'b0;
                    end else if (tick == CW'(TICK_DIV - 1)) begin
                        tick       <= '0;
                        trace_lane <= step_lane;
                        if (trace_row == RW'(ROWS - 1)) begin
                            result       <= step_lane;
                            result_valid <= 1'b1;
                            state        <= DONE;
                            alarm        <= 1'b1;
                        end else begin
                            trace_row <= trace_row + RW'(1);
                        end
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.enter || bus.esc) begin
                        state <= SELECT;
                        alarm <= 1'b0;
                    end
                end
                default: begin
                    state <= EDIT;
                    norm  <= 1'b1;
                    alarm <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rung_map     = rungs;
    assign bus.cursor_row   = cursor_row;
    assign bus.cursor_col   = cursor_col;
    assign bus.start_lane   = start_lane;
    assign bus.trace_lane   = trace_lane;
    assign bus.trace_row    = trace_row;
    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.alarm        = alarm;
    assign bus.norm         = norm;
endmodule

// File: tb/tb_ladder_trace.sv
// tb/tb_ladder_trace.sv - scoreboard bench for the ladder-lottery engine
module tb_ladder_trace;
    localparam int LANES    = 4;
    localparam int ROWS     = 4;
    localparam int TICK_DIV = 3;

    localparam int B_ESC   = 32;
    localparam int B_ENTER = 16;
    localparam int B_UP    = 8;
    localparam int B_DOWN  = 4;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ladder_trace_if #(.LANES(LANES), .ROWS(ROWS)) bus();

    ladder_trace #(.LANES(LANES), .ROWS(ROWS), .TICK_DIV(TICK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned exp_q[$];
    int unsigned e;

    // One clock with the given button pulses, outputs sampled 1 time unit after the edge
    task automatic step(input int btn);
        {bus.esc, bus.enter, bus.up, bus.down, bus.left, bus.right} = 6'(btn);
        @(posedge clk);
        #1;
        {bus.esc, bus.enter, bus.up, bus.down, bus.left, bus.right} = 6'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(0);
        step(0);
        rst = 1'b0;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        e = exp_q.pop_front(); vectors++;
        if (bus.rung_map !== e) begin miscompares++; $display("FAIL reset_map got %0h want %0h", bus.rung_map, e); end
        e = exp_q.pop_front(); vectors++;
        if (bus.norm !== e[0]) begin miscompares++; $display("FAIL reset_norm got %0b want %0b", bus.norm, e[0]); end
        e = exp_q.pop_front(); vectors++;
        if (bus.alarm !== e[0]) begin miscompares++; $display("FAIL reset_alarm got %0b want %0b", bus.alarm, e[0]); end
        e = exp_q.pop_front(); vectors++;
        if ({bus.cursor_row, bus.cursor_col} !== e[3:0]) begin miscompares++; $display("FAIL reset_cursor got %0h want %0h", {bus.cursor_row, bus.cursor_col}, e); end
        e = exp_q.pop_front(); vectors++;
        if (bus.result_valid !== e[0]) begin miscompares++; $display("FAIL reset_rv got %0b want %0b", bus.result_valid, e[0]); end
        e = exp_q.pop_front(); vectors++;
        if ({bus.start_lane, bus.result, bus.trace_lane, bus.trace_row} !== e[7:0]) begin miscompares++; $display("FAIL reset_lanes got %0h want %0h", {bus.start_lane, bus.result, bus.trace_lane, bus.trace_row}, e); end
    endtask

    task automatic test_legality;
        int codes[4] = '{B_ENTER, B_RIGHT | 64, B_RIGHT | 64, B_RIGHT | 64};
        int maps[4]  = '{32'h001, 32'h001, 32'h005, 32'h004};
        for (int i = 0; i < 4; i++) begin
            if (codes[i] & 64) step(codes[i] & 63);
            exp_q.push_back(maps[i]);
            step(B_ENTER);
            e = exp_q.pop_front(); vectors++;
            if (bus.rung_map !== e) begin miscompares++; $display("FAIL legality_%0d rung_map got %0h want %0h", i, bus.rung_map, e); end
        end
    endtask

    task automatic test_wrap;
        exp_q.push_back(2);
        step(B_LEFT);
        e = exp_q.pop_front(); vectors++;
        if (bus.cursor_col !== e[1:0]) begin miscompares++; $display("FAIL wrap_left col got %0d want %0d", bus.cursor_col, e); end
        exp_q.push_back(3);
        step(B_UP);
        e = exp_q.pop_front(); vectors++;
        if (bus.cursor_row !== e[1:0]) begin miscompares++; $display("FAIL wrap_up row got %0d want %0d", bus.cursor_row, e); end
        step(B_DOWN);
        step(B_RIGHT);
        step(B_ESC);
    endtask

    task automatic test_full_trace;
        // rungs at (0,0) and (1,1)
        step(B_ENTER);
        step(B_DOWN);
        step(B_RIGHT);
        exp_q.push_back(32'h011);
        step(B_ENTER);
        e = exp_q.pop_front(); vectors++;
        if (bus.rung_map !== e) begin miscompares++; $display("FAIL trace_setup map got %0h want %0h", bus.rung_map, e); end
        bus.mode = 1'b1;
        exp_q.push_back(0);
        step(0);
        e = exp_q.pop_front(); vectors++;
        if (bus.norm !== e[0]) begin miscompares++; $display("FAIL select_norm got %0b want %0b", bus.norm, e[0]); end
        exp_q.push_back(3);
        step(B_LEFT);
        e = exp_q.pop_front(); vectors++;
        if (bus.start_lane !== e[1:0]) begin miscompares++; $display("FAIL select_left start got %0d want %0d", bus.start_lane, e); end
        exp_q.push_back(0);
        step(B_RIGHT);
        e = exp_q.pop_front(); vectors++;
        if (bus.start_lane !== e[1:0]) begin miscompares++; $display("FAIL wrap_select start got %0d want %0d", bus.start_lane, e); end
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2);
        step(B_ENTER);
        for (int k = 2; k <= 13; k++) begin
            step(0);
            if (k % 3 == 1) begin
                e = exp_q.pop_front(); vectors++;
                if (bus.trace_lane !== e[1:0]) begin miscompares++; $display("FAIL trace_step_%0d lane got %0d want %0d", k, bus.trace_lane, e); end
            end
            if (k == 12) begin
                vectors++;
                if (bus.alarm !== 1'b0) begin miscompares++; $display("FAIL alarm_early got %0b want 0", bus.alarm); end
            end
        end
        exp_q.push_back({1'b1, 1'b1, 2'd2});
        e = exp_q.pop_front(); vectors++;
        if ({bus.alarm, bus.result_valid, bus.result} !== e[3:0]) begin miscompares++; $display("FAIL trace_done {alarm,rv,result} got %0h want %0h", {bus.alarm, bus.result_valid, bus.result}, e); end
        exp_q.push_back(0);
        step(B_ENTER);
        e = exp_q.pop_front(); vectors++;
        if ({bus.alarm, bus.norm} !== e[1:0]) begin miscompares++; $display("FAIL done_exit {alarm,norm} got %0h want %0h", {bus.alarm, bus.norm}, e); end
    endtask

    task automatic test_abort;
        step(B_ENTER);
        for (int k = 0; k < 4; k++) step(0);
        exp_q.push_back({2'd2, 1'b1, 1'b0, 2'd1, 2'd1});
        step(B_ESC);
        e = exp_q.pop_front(); vectors++;
        if ({bus.result, bus.result_valid, bus.alarm, bus.trace_lane, bus.trace_row} !== e[7:0]) begin miscompares++; $display("FAIL abort_esc got %0h want %0h", {bus.result, bus.result_valid, bus.alarm, bus.trace_lane, bus.trace_row}, e); end
        for (int k = 0; k < 4; k++) step(0);
        exp_q.push_back({2'd1, 2'd1});
        step(B_RIGHT);
        e = exp_q.pop_front(); vectors++;
        if ({bus.trace_row, bus.start_lane} !== e[3:0]) begin miscompares++; $display("FAIL abort_frozen {row,start} got %0h want %0h", {bus.trace_row, bus.start_lane}, e); end
        step(B_LEFT);
        step(B_ENTER);
        step(0);
        bus.mode = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 12'h011});
        step(B_ENTER);
        e = exp_q.pop_front(); vectors++;
        if ({bus.norm, bus.alarm, bus.rung_map} !== e[13:0]) begin miscompares++; $display("FAIL abort_mode got %0h want %0h", {bus.norm, bus.alarm, bus.rung_map}, e); end
    endtask

    task automatic test_priority;
        step(B_ESC);
        step(B_UP);
        step(B_LEFT);
        step(B_ENTER);
        step(B_RIGHT);
        step(B_RIGHT);
        exp_q.push_back(32'h005);
        step(B_ENTER);
        e = exp_q.pop_front(); vectors++;
        if (bus.rung_map !== e) begin miscompares++; $display("FAIL prio_setup map got %0h want %0h", bus.rung_map, e); end
        exp_q.push_back({2'd2, 12'h000});
        step(B_ESC | B_ENTER);
        e = exp_q.pop_front(); vectors++;
        if ({bus.cursor_col, bus.rung_map} !== e[13:0]) begin miscompares++; $display("FAIL prio_esc_enter got %0h want %0h", {bus.cursor_col, bus.rung_map}, e); end
        exp_q.push_back({1'b0, 2'd0, 2'd2, 12'h004});
        step(B_ENTER | B_RIGHT);
        e = exp_q.pop_front(); vectors++;
        if ({bus.result_valid, bus.cursor_row, bus.cursor_col, bus.rung_map} !== e[16:0]) begin miscompares++; $display("FAIL prio_enter_right got %0h want %0h", {bus.result_valid, bus.cursor_row, bus.cursor_col, bus.rung_map}, e); end
    endtask

    task automatic test_reset_mid_trace;
        bus.mode = 1'b1;
        step(0);
        step(B_RIGHT);
        step(B_RIGHT);
        step(B_ENTER);
        exp_q.push_back(3);
        for (int k = 0; k < 4; k++) step(0);
        e = exp_q.pop_front(); vectors++;
        if (bus.trace_lane !== e[1:0]) begin miscompares++; $display("FAIL mid_trace lane got %0d want %0d", bus.trace_lane, e); end
        rst = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 12'h000, 8'h00});
        step(0);
        rst = 1'b0;
        e = exp_q.pop_front(); vectors++;
        if ({bus.norm, bus.alarm, bus.result_valid, bus.rung_map, bus.start_lane, bus.result, bus.trace_lane, bus.trace_row} !== e[22:0]) begin
            miscompares++;
            $display("FAIL reset_mid_trace got %0h want %0h", {bus.norm, bus.alarm, bus.result_valid, bus.rung_map, bus.start_lane, bus.result, bus.trace_lane, bus.trace_row}, e);
        end
        bus.mode = 1'b0;
    endtask

    initial begin
        {bus.esc, bus.enter, bus.up, bus.down, bus.left, bus.right, bus.mode} = 7'b0;
        test_reset();
        test_legality();
        test_wrap();
        test_full_trace();
        test_abort();
        test_priority();
        test_reset_mid_trace();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ladder_trace.md
# ladder_trace

Parametrised ladder-lottery (amidakuji) engine for the board game set: `LANES` vertical lanes and `ROWS` rung slots. The player edits rungs with a cursor, selects a start lane, and watches a timed trace descend row by row to a result lane, with `alarm` raised on arrival. It sits between the debounced button front end and the display/LED driver, replacing the fixed six-lane ladder with a generic width/depth version that adds rung legality checking, trace animation, abort and result readback.

## Interface
- `LANES`, default 6: number of vertical lanes, 2..16.
- `ROWS`, default 8: rung rows, 1..32.
- `TICK_DIV`, default 25_000_000: clock cycles per trace row step, ≥1.
- `LW`, derived = max(1, $clog2(LANES)): lane index width.
- `RW`, derived = max(1, $clog2(ROWS)): row index width.

Ports:
- `clk` in 1: system clock. All logic runs on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `up`, `down`, `left`, `right`, `enter`, `esc` in 1 each: single-cycle, debounced button pulses.
- `mode` in 1: level input. 0 = edit, 1 = play.
- `rung_map` out ROWS*(LANES-1): bit r*(LANES-1)+c set = rung between lane c and lane c+1 in row r.
- `cursor_row` out RW: edit cursor row.
- `cursor_col` out LW: edit cursor column, range 0..LANES-2.
- `start_lane` out LW: selected start lane.
- `trace_lane` out LW: current trace lane.
- `trace_row` out RW: current trace row.
- `result` out LW: last completed trace result.
- `result_valid` out 1: `result` holds a completed trace.
- `alarm` out 1: high while in state DONE.
- `norm` out 1: high while in state EDIT.

## Operation
- States: EDIT, SELECT, TRACE, DONE. All outputs are registered.
- Reset values:
  - State EDIT.
  - All rungs 0.
  - Cursor (0,0).
  - `start_lane`, `trace_lane`, `trace_row`, `result` = 0.
  - `result_valid` = 0, `alarm` = 0, `norm` = 1.
- Global priority: `mode`=0 in any non-EDIT state forces EDIT next cycle; that cycle's buttons are ignored.
- Button priority within a cycle: esc > enter > up > down > left > right. Only the highest-priority pulse acts.
- EDIT:
  - `up` moves to row-1 and `down` to row+1, wrapping between 0 and ROWS-1.
  - `left` and `right` move the column, wrapping between 0 and LANES-2.
  - `enter` toggles the rung at the cursor.
  - Setting a rung is rejected, with no change, if the neighbour at col-1 or col+1 in the same row is set. Clearing is always allowed.
  - `esc` clears all rungs.
  - `mode`=1 → SELECT.
- SELECT:
  - `left` and `right` move `start_lane`, wrapping over 0..LANES-1.
  - `enter` → TRACE with `trace_lane`=`start_lane`, `trace_row`=0 and the tick counter cleared.
  - `esc` → EDIT.
- TRACE:
  - Rungs are frozen.
  - Each time the tick counter reaches TICK_DIV-1, the row at `trace_row` is evaluated:
    - if rung(row, lane) is set, lane+1;
    - else if lane>0 and rung(row, lane-1) is set, lane-1;
    - otherwise the lane is unchanged.
  - After evaluating row ROWS-1: `result` ← new lane, `result_valid` ← 1, state → DONE. `trace_row` holds at ROWS-1.
  - Otherwise `trace_row` increments.
  - `esc` aborts to SELECT. `result` and `result_valid` are unchanged.
- DONE: `alarm`=1. `enter` or `esc` → SELECT.
- Leaving DONE or TRACE clears `alarm` on the next cycle.
- Editing a rung in EDIT clears `result_valid`.

## Timing
- Button pulse at edge n takes effect on the outputs after edge n+1. Latency is 1 cycle.
- A trace row step occurs every TICK_DIV cycles. The first step comes TICK_DIV cycles after the edge that enters TRACE.
- Enter in SELECT to `alarm`=1 takes 1 + ROWS*TICK_DIV cycles.
- The tick counter is ceil(log2(TICK_DIV+1)) bits wide. It resets to 0 on TRACE entry and on every step.
- Reset mid-trace: the next cycle shows exact reset values, including an empty rung map.
- `mode` is sampled every cycle. No edge detection is used; the state follows the level.

## Test plan
Bench parameters: LANES=4, ROWS=4, TICK_DIV=3.

1. Reset with buttons held idle → state EDIT, `rung_map`=0x000, `norm`=1, `alarm`=0, cursor (0,0), `result_valid`=0.
2. Rung legality:
   - enter at (0,0) → `rung_map`=0x001;
   - right, enter at (0,1) → rejected, map stays 0x001;
   - right, enter at (0,2) → map 0x005;
   - enter at (0,0) again → 0x004.
3. Wrap: left at col 0 → col 2; up at row 0 → row 3; right in SELECT at lane 3 → lane 0.
4. Full trace:
   - rungs at (0,0) and (1,1), start lane 0, then enter;
   - `trace_lane` goes 0→1→2→2→2;
   - `result`=2, `result_valid`=1, `alarm`=1 exactly 13 cycles after enter;
   - enter → SELECT and `alarm`=0.
5. Abort:
   - esc at 5 cycles into TRACE → SELECT next cycle, `result` and `result_valid` unchanged;
   - `mode`=0 during TRACE → EDIT, `norm`=1, rungs intact.
6. Priority: esc+enter in the same cycle in EDIT with map 0x005 → map 0x000. enter+right in the same cycle → toggle only, cursor unchanged.
